// File: rtl/line_slot_scheduler_pkg.sv
// hp2vga_line_pkg: shared state encodings and default sizes for the line slot scheduler.
package hp2vga_line_pkg;
   typedef enum logic {W_IDLE, W_ACTIVE} w_state_t;
   typedef enum logic {R_IDLE, R_ACTIVE} r_state_t;
   localparam int DEF_NUM_SLOTS = 4;
   localparam int DEF_SLOT_BITS = 2;
   localparam int STAT_W = 16;
endpackage

// File: rtl/line_slot_scheduler_if.sv
// line_slot_scheduler_if: writer/reader event pulses and slot outputs of the scheduler.
// LINE_STATS_EN adds the drop/repeat statistics counters.
interface line_slot_scheduler_if #(parameter int SLOT_BITS = 2);
   logic                 flush;
   logic                 wr_line_start;
   logic                 wr_line_done;
   logic [SLOT_BITS-1:0] wr_slot;
   logic                 rd_line_start;
   logic                 rd_line_done;
   logic [SLOT_BITS-1:0] rd_slot;
   logic                 rd_repeat;
   logic [SLOT_BITS:0]   level;
   logic                 drop;
   logic                 proto_err;
`ifdef LINE_STATS_EN
   logic [15:0]          drop_cnt;
   logic [15:0]          repeat_cnt;
   modport master (output flush, wr_line_start, wr_line_done, rd_line_start, rd_line_done,
                   input wr_slot, rd_slot, rd_repeat, level, drop, proto_err, drop_cnt, repeat_cnt);
   modport slave (input flush, wr_line_start, wr_line_done, rd_line_start, rd_line_done,
                  output wr_slot, rd_slot, rd_repeat, level, drop, proto_err, drop_cnt, repeat_cnt);
`else
   modport master (output flush, wr_line_start, wr_line_done, rd_line_start, rd_line_done,
                   input wr_slot, rd_slot, rd_repeat, level, drop, proto_err);
   modport slave (input flush, wr_line_start, wr_line_done, rd_line_start, rd_line_done,
                  output wr_slot, rd_slot, rd_repeat, level, drop, proto_err);
`endif
endinterface

// File: rtl/line_slot_scheduler_sat_counter.sv
// sat_counter: saturating up-counter with synchronous clear.
module sat_counter #(parameter int W = 16) (
   input  logic         CLK,
   input  logic         clear,
   input  logic         inc,
   output logic [W-1:0] cnt
);
   logic [W-1:0] cnt_q, cnt_d;
   always_comb cnt_d = clear ? '0 : (inc && ~&cnt_q) ? cnt_q + W'(1) : cnt_q;
   always_ff @(posedge CLK) cnt_q <= cnt_d;
   assign cnt = cnt_q;
endmodule

// File: rtl/line_slot_scheduler.sv
// line_slot_scheduler: ring of line slots shared by RX writer and TX reader; drops on overrun, repeats on underrun.
// Optional LINE_STATS_EN adds saturating DROP_CNT/REPEAT_CNT counters.
module line_slot_scheduler
   import hp2vga_line_pkg::*;
#(
   parameter int NUM_SLOTS = DEF_NUM_SLOTS,
   parameter int SLOT_BITS = DEF_SLOT_BITS
) (
   input logic                   CLK,
   input logic                   RST_N,
   line_slot_scheduler_if.slave  bus
);
   localparam logic [SLOT_BITS:0]   MAX_CNT = (SLOT_BITS+1)'(NUM_SLOTS-1);
   localparam logic [SLOT_BITS-1:0] LAST_SLOT = SLOT_BITS'(NUM_SLOTS-1);
   w_state_t             w_st_q, w_st_d;
   r_state_t             r_st_q, r_st_d;
   logic [SLOT_BITS-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, rd_slot_q, rd_slot_d;
   logic [SLOT_BITS:0]   count_q, count_d;
   logic                 rd_repeat_q, rd_repeat_d, drop_q, drop_d, proto_err_q, proto_err_d;
   logic                 w_go, r_go, cmt, rel, empty;
   always_comb begin
      w_go = w_st_q == W_ACTIVE && bus.wr_line_done;
      r_go = r_st_q == R_IDLE && bus.rd_line_start;
      rel = r_st_q == R_ACTIVE && bus.rd_line_done && !rd_repeat_q;
      cmt = w_go && (count_q < MAX_CNT || rel);
      empty = count_q == '0;
      drop_d = w_go && !cmt;
      wr_ptr_d = wr_ptr_q + SLOT_BITS'(cmt);
      rd_ptr_d = rd_ptr_q + SLOT_BITS'(rel);
      count_d = count_q + (SLOT_BITS+1)'(cmt) - (SLOT_BITS+1)'(rel);
      w_st_d = bus.wr_line_start ? W_ACTIVE : bus.wr_line_done ? W_IDLE : w_st_q;
      r_st_d = r_go ? R_ACTIVE : (r_st_q == R_ACTIVE && bus.rd_line_done) ? R_IDLE : r_st_q;
      // underrun replays the previous slot, which the writer cannot touch while count is zero
      rd_slot_d = r_go ? (empty ? rd_ptr_q - SLOT_BITS'(1) : rd_ptr_q) : rd_slot_q;
      rd_repeat_d = r_go ? empty : rd_repeat_q;
      proto_err_d = proto_err_q || (bus.wr_line_done && w_st_q == W_IDLE) ||
                    (bus.rd_line_start && r_st_q == R_ACTIVE) ||
                    (bus.rd_line_done && r_st_q == R_IDLE);
   end
   always_ff @(posedge CLK) begin
      if (!RST_N || bus.flush) begin
         w_st_q <= W_IDLE;
         r_st_q <= R_IDLE;
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q <= '0;
         rd_slot_q <= LAST_SLOT;
         rd_repeat_q <= 1'b0;
         drop_q <= 1'b0;
         proto_err_q <= 1'b0;
      end else begin
         w_st_q <= w_st_d;
         r_st_q <= r_st_d;
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q <= count_d;
         rd_slot_q <= rd_slot_d;
         rd_repeat_q <= rd_repeat_d;
         drop_q <= drop_d;
         proto_err_q <= proto_err_d;
      end
   end
   assign bus.wr_slot = wr_ptr_q;
   assign bus.rd_slot = rd_slot_q;
   assign bus.rd_repeat = rd_repeat_q;
   assign bus.level = count_q;
   assign bus.drop = drop_q;
   assign bus.proto_err = proto_err_q;
`ifdef LINE_STATS_EN
   sat_counter #(.W(STAT_W)) u_drop_cnt (
      .CLK(CLK), .clear(!RST_N), .inc(drop_q), .cnt(bus.drop_cnt)
   );
   sat_counter #(.W(STAT_W)) u_repeat_cnt (
      .CLK(CLK), .clear(!RST_N), .inc(r_go && empty && !bus.flush), .cnt(bus.repeat_cnt)
   );
`endif
endmodule

// File: tb/tb_line_slot_scheduler.sv
// tb_line_slot_scheduler: directed vectors into a scoreboard queue, checked by a negedge monitor.
module tb_line_slot_scheduler;
   typedef struct {int due; int kind; logic [15:0] exp; string name;} sb_t;
   logic CLK = 1'b0, RST_N = 1'b0;
   int   cyc = 0, nvec = 0, nerr = 0;
   bit   done = 1'b0;
   sb_t  q[$];
   sb_t  s;
   logic [15:0] act;
   line_slot_scheduler_if #(.SLOT_BITS(2)) bus();
   line_slot_scheduler #(.NUM_SLOTS(4), .SLOT_BITS(2)) dut (.CLK(CLK), .RST_N(RST_N), .bus(bus));
   always #5 CLK = ~CLK;
   always @(posedge CLK) cyc <= cyc + 1;
   function automatic logic [15:0] e(input int ws, rs, rp, lv, d, p);
      return {6'd0, 2'(ws), 2'(rs), 1'(rp), 3'(lv), 1'(d), 1'(p)};
   endfunction
   task automatic step(input bit r, f, ws, wd, rs, rd, input logic [15:0] x, input string n);
      @(posedge CLK); #1;
      RST_N = !r;
      bus.flush = f;
      bus.wr_line_start = ws;
      bus.wr_line_done = wd;
      bus.rd_line_start = rs;
      bus.rd_line_done = rd;
      q.push_back('{due: cyc + 1, kind: 0, exp: x, name: n});
      @(posedge CLK); #1;
      RST_N = 1'b1;
      {bus.flush, bus.wr_line_start, bus.wr_line_done, bus.rd_line_start, bus.rd_line_done} = '0;
   endtask
   always @(negedge CLK) begin
      while (q.size() != 0 && (q[0].due <= cyc || done)) begin
         s = q.pop_front();
         act = {6'd0, bus.wr_slot, bus.rd_slot, bus.rd_repeat, bus.level, bus.drop, bus.proto_err};
`ifdef LINE_STATS_EN
         if (s.kind == 1) act = bus.drop_cnt;
         if (s.kind == 2) act = bus.repeat_cnt;
`endif
         nvec++;
         if (s.due != cyc || act !== s.exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h (cycle %0d due %0d)", s.name, act, s.exp, cyc, s.due);
         end
      end
      if (!done && cyc > 90000) begin
         nerr++;
         $display("FAIL timeout: stimulus did not finish by cycle %0d, required done", cyc);
         done = 1'b1;
      end
      if (done) begin
         $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
         $finish;
      end
   end
   initial begin
      {bus.flush, bus.wr_line_start, bus.wr_line_done, bus.rd_line_start, bus.rd_line_done} = '0;
      step(1, 0, 1, 0, 0, 0, e(0, 3, 0, 0, 0, 0), "reset_hold");
      step(0, 0, 0, 0, 0, 0, e(0, 3, 0, 0, 0, 0), "reset_state");
      step(0, 0, 1, 0, 0, 0, e(0, 3, 0, 0, 0, 0), "w1_start");
      step(0, 0, 0, 1, 0, 0, e(1, 3, 0, 1, 0, 0), "w1_done");
      step(0, 0, 1, 0, 0, 0, e(1, 3, 0, 1, 0, 0), "w2_start");
      step(0, 0, 0, 1, 0, 0, e(2, 3, 0, 2, 0, 0), "w2_done");
      step(0, 0, 1, 0, 0, 0, e(2, 3, 0, 2, 0, 0), "w3_start");
      step(0, 0, 0, 1, 0, 0, e(3, 3, 0, 3, 0, 0), "w3_done");
      step(0, 0, 1, 0, 0, 0, e(3, 3, 0, 3, 0, 0), "w4_start");
      step(0, 0, 0, 1, 0, 0, e(3, 3, 0, 3, 1, 0), "w4_drop");
      step(0, 0, 0, 0, 0, 0, e(3, 3, 0, 3, 0, 0), "drop_one_cycle");
      step(0, 0, 0, 0, 1, 0, e(3, 0, 0, 3, 0, 0), "rd_slot0");
      step(0, 0, 1, 0, 0, 0, e(3, 0, 0, 3, 0, 0), "w5_start");
      step(0, 0, 0, 1, 0, 1, e(0, 0, 0, 3, 0, 0), "commit_release");
      step(0, 0, 0, 0, 1, 0, e(0, 1, 0, 3, 0, 0), "rd_slot1");
      step(0, 0, 0, 0, 0, 1, e(0, 1, 0, 2, 0, 0), "rd_release");
      step(0, 0, 1, 0, 0, 0, e(0, 1, 0, 2, 0, 0), "w6_start");
      step(0, 1, 0, 1, 0, 0, e(0, 3, 0, 0, 0, 0), "flush_vs_done");
      step(0, 0, 0, 0, 1, 0, e(0, 3, 1, 0, 0, 0), "underrun_start");
      step(0, 0, 0, 0, 0, 1, e(0, 3, 1, 0, 0, 0), "repeat_done");
      step(0, 0, 0, 0, 1, 0, e(0, 3, 1, 0, 0, 0), "repeat_again");
      step(0, 0, 0, 0, 0, 1, e(0, 3, 1, 0, 0, 0), "repeat_done2");
      step(0, 0, 0, 0, 0, 1, e(0, 3, 1, 0, 0, 1), "rd_done_idle");
      step(0, 0, 0, 0, 0, 0, e(0, 3, 1, 0, 0, 1), "proto_sticky");
      step(0, 1, 0, 0, 0, 0, e(0, 3, 0, 0, 0, 0), "flush_clears");
      step(0, 0, 0, 1, 0, 0, e(0, 3, 0, 0, 0, 1), "wr_done_idle");
      step(0, 1, 0, 0, 0, 0, e(0, 3, 0, 0, 0, 0), "flush2");
      step(0, 0, 0, 0, 1, 0, e(0, 3, 1, 0, 0, 0), "underrun3");
      step(0, 0, 0, 0, 1, 0, e(0, 3, 1, 0, 0, 1), "rd_start_active");
      step(0, 1, 0, 0, 0, 0, e(0, 3, 0, 0, 0, 0), "flush3");
      step(0, 0, 1, 0, 0, 0, e(0, 3, 0, 0, 0, 0), "w7_start");
      step(0, 0, 0, 1, 1, 0, e(1, 3, 1, 1, 0, 0), "commit_with_start");
      step(0, 0, 0, 0, 0, 1, e(1, 3, 1, 1, 0, 0), "repeat_no_release");
      step(0, 0, 0, 0, 1, 0, e(1, 0, 0, 1, 0, 0), "rd_after_commit");
      step(0, 0, 1, 0, 0, 0, e(1, 0, 0, 1, 0, 0), "w8_start");
      step(0, 0, 0, 1, 0, 0, e(2, 0, 0, 2, 0, 0), "w8_done");
      step(0, 0, 1, 0, 0, 0, e(2, 0, 0, 2, 0, 0), "w9_start");
      step(0, 0, 0, 1, 0, 0, e(3, 0, 0, 3, 0, 0), "w9_done");
      step(0, 0, 1, 0, 0, 0, e(3, 0, 0, 3, 0, 0), "w10_start");
      step(0, 0, 0, 1, 0, 0, e(3, 0, 0, 3, 1, 0), "w10_drop_held");
      step(0, 0, 0, 0, 0, 1, e(3, 0, 0, 2, 0, 0), "release_after_drop");
`ifdef LINE_STATS_EN
      @(posedge CLK); #1;
      bus.wr_line_start = 1'b1;
      bus.wr_line_done = 1'b1;
      repeat (70000) @(posedge CLK);
      #1;
      {bus.wr_line_start, bus.wr_line_done} = '0;
      repeat (2) @(posedge CLK);
      #1;
      q.push_back('{due: cyc, kind: 1, exp: 16'hFFFF, name: "drop_cnt_sat"});
      q.push_back('{due: cyc, kind: 2, exp: 16'd4, name: "repeat_cnt"});
`endif
      step(1, 0, 0, 0, 0, 0, e(0, 3, 0, 0, 0, 0), "reset_again");
      step(0, 0, 0, 0, 0, 0, e(0, 3, 0, 0, 0, 0), "reset_again_idle");
      repeat (3) @(posedge CLK);
      done = 1'b1;
   end
endmodule

// File: doc/line_slot_scheduler.md
Name: line_slot_scheduler

Overview:
Allocates the slots of the line buffer RAM between the video writer (RX side) and the VGA reader (TX side). It is a ring of NUM_SLOTS line slots with commit/release accounting. When the writer outruns the reader, whole lines are dropped. When the reader outruns the writer, the last completed line is repeated. Runs in the TX clock domain; RX events arrive as single-cycle pulses already synchronized by the top level. The top level forms the RAM address as {slot, pixel}.

Parameters:
NUM_SLOTS, 4, number of line slots in the RAM; power of two, minimum 4
SLOT_BITS, 2, log2(NUM_SLOTS)

Ports:
CLK  in  1  system clock; all logic on rising edge
RST_N  in  1  synchronous active-low reset
FLUSH  in  1  pulse at frame start; discards all lines
WR_LINE_START  in  1  pulse: writer begins a line in WR_SLOT
WR_LINE_DONE  in  1  pulse: writer finished the current line
WR_SLOT  out  SLOT_BITS  slot the writer must fill
RD_LINE_START  in  1  pulse: reader requests the next line
RD_LINE_DONE  in  1  pulse: reader finished the current line
RD_SLOT  out  SLOT_BITS  slot the reader must read
RD_REPEAT  out  1  high while the current read is a repeat
LEVEL  out  SLOT_BITS+1  committed, unreleased line count
DROP  out  1  one-cycle pulse: a completed line was discarded
PROTO_ERR  out  1  sticky: illegal pulse seen; cleared by reset or FLUSH

Behaviour:
- Interface: one clock (CLK); reset is synchronous and active-low (RST_N). The reset and FLUSH state is identical: wr_ptr=0, rd_ptr=0, count=0, writer W_IDLE, reader R_IDLE, WR_SLOT=0, RD_SLOT=NUM_SLOTS-1, RD_REPEAT=0, LEVEL=0, DROP=0, PROTO_ERR=0.
- FLUSH has priority over every other input in the same cycle.
- Invariant: wr_ptr = rd_ptr + count (mod NUM_SLOTS); count <= NUM_SLOTS-1. The writer never writes a slot the reader holds.
- Writer FSM, W_IDLE/W_ACTIVE:
  - WR_LINE_START in W_IDLE goes to W_ACTIVE.
  - WR_LINE_START in W_ACTIVE restarts the same slot; the partial line is abandoned and there is no error.
  - WR_LINE_DONE in W_ACTIVE commits the line and goes to W_IDLE.
  - Commit is allowed if count < NUM_SLOTS-1, or if a non-repeat release happens in the same cycle. An allowed commit does wr_ptr++ and count++.
  - Otherwise the line is dropped: DROP pulses the next cycle and wr_ptr is unchanged.
  - WR_LINE_DONE in W_IDLE is ignored and sets PROTO_ERR.
- Reader FSM, R_IDLE/R_ACTIVE:
  - RD_LINE_START in R_IDLE with count >= 1: RD_SLOT <= rd_ptr, RD_REPEAT <= 0.
  - RD_LINE_START in R_IDLE with count == 0 (underrun): RD_SLOT <= rd_ptr-1 (mod NUM_SLOTS), RD_REPEAT <= 1.
  - Either way the reader goes to R_ACTIVE. RD_SLOT and RD_REPEAT are valid the cycle after the start pulse and stay stable until the next start.
  - RD_LINE_DONE in R_ACTIVE with RD_REPEAT=0 releases the line: rd_ptr++, count--. A repeat read releases nothing. Either way the reader returns to R_IDLE.
  - RD_LINE_START in R_ACTIVE, or RD_LINE_DONE in R_IDLE, is ignored and sets PROTO_ERR.
- Simultaneous commit and release: count is unchanged and both pointers advance.
- A commit and an RD_LINE_START in the same cycle: the start decision uses the pre-commit count.
- The repeat slot rd_ptr-1 never equals wr_ptr while count == 0. Hence no tearing during a repeat.
- WR_SLOT = wr_ptr and LEVEL = count, both registered; each updates the cycle after the event.
- Pointer arithmetic is modulo NUM_SLOTS via natural SLOT_BITS wrap. count is SLOT_BITS+1 wide.

Optional Feature:
LINE_STATS_EN:
- Defined: adds outputs DROP_CNT[15:0] and REPEAT_CNT[15:0], both saturating at 16'hFFFF.
  - DROP_CNT increments on each DROP.
  - REPEAT_CNT increments on each repeat read start.
  - Both clear on reset only, not on FLUSH.
- Undefined: these ports and counters do not exist, and the core behaviour is identical.

Decomposition:
- Package hp2vga_line_pkg holds:
  - writer state encoding (W_IDLE, W_ACTIVE) and reader state encoding (R_IDLE, R_ACTIVE)
  - default NUM_SLOTS/SLOT_BITS constants
  - STAT_W=16
- One sub-module, sat_counter (width parameter, inc, clear), instantiated twice under LINE_STATS_EN.

Test Plan:
- Reset, then write 3 lines, no reads -> WR_SLOT 0,1,2,3; LEVEL=3; no DROP.
- Write a 4th line from that state -> DROP pulses one cycle; WR_SLOT stays 3; LEVEL stays 3.
- LEVEL=0 after reset, RD_LINE_START -> RD_SLOT=3, RD_REPEAT=1. After RD_LINE_DONE, LEVEL=0 and rd_ptr is unchanged (the next read also gives RD_SLOT=3).
- Reader reading slot 0 with LEVEL=3: WR_LINE_DONE and RD_LINE_DONE in the same cycle -> commit accepted, no DROP, LEVEL=3, WR_SLOT=0, rd_ptr=1.
- FLUSH asserted alongside WR_LINE_DONE with LEVEL=2 -> all state returns to reset values; no DROP; PROTO_ERR=0.
- RD_LINE_DONE while R_IDLE -> PROTO_ERR=1 and stays set until FLUSH. With LINE_STATS_EN, force 70000 drops -> DROP_CNT=16'hFFFF.
